tone_player: RTL and testbench
==============================

Name: tone_player

Overview:
- Consumer end of the key-event interface produced by the microphone/keyboard front ends.
- Accepts key_valid / key_code / key_released events and plays the matching solfege note (DO..SI, C4..B4) as a square wave on the board audio output.
- Enforces a minimum note duration.
- Sits between the key-event source and the AUD_PWM/AUD_SD pins.

Parameters:
- MIN_HOLD, 25000000: minimum play time in clk cycles after the latest accepted note (0.25 s at 100 MHz).
- TEST_DIV, 1: divisor applied to every half-period constant; set >1 only in simulation.
- DECAY_STEP, 65536: clk cycles per envelope decrement; used only with DECAY_EN.
- DECAY_FLOOR, 32: lowest envelope duty value; used only with DECAY_EN.

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  synchronous active-high reset
- key_valid  input  1  one-cycle strobe; key_code is valid in this cycle
- key_code  input  8  scancode: 1A=DO, 22=RE, 21=MI, 2A=FA, 32=SO, 31=LA, 3A=SI
- key_released  input  1  one-cycle strobe, note release request
- AUD_PWM  output  1  audio waveform
- AUD_SD  output  1  amplifier enable, 1 = on
- busy  output  1  1 while in PLAY
- note_id  output  3  current note, 1..7; 0 when idle

Behaviour:
- Reset: synchronous, active-high, sampled on posedge clk. All outputs are 0; state = IDLE; all counters are 0; release_pending = 0.
- Half-period table, in cycles, before division by TEST_DIV: DO 191113, RE 170262, MI 151686, FA 143172, SO 127551, LA 113636, SI 101239.
  - HALF = table / TEST_DIV, using integer division.
  - tone_cnt is 18 bits wide.
- Unknown key_code (not in the table) with key_valid: ignored in every state; no output changes.
- IDLE state:
  - AUD_SD = 0, AUD_PWM = 0, note_id = 0, busy = 0.
  - Known key_valid at cycle N: latch HALF and note_id; tone_cnt = 0; tone = 1; hold_cnt = 0; release_pending = 0; go to PLAY.
  - At cycle N+1: AUD_SD = 1, AUD_PWM = 1, busy = 1, note_id valid.
  - key_released while in IDLE is ignored.
- PLAY state, tone generation:
  - tone_cnt increments each cycle.
  - When tone_cnt == HALF-1: tone_cnt = 0 and tone toggles.
  - Output period = 2*HALF cycles, 50% duty. AUD_PWM = tone.
- PLAY state, hold counter:
  - hold_cnt increments each cycle and saturates at MIN_HOLD.
- PLAY state, new key:
  - Known key_valid, same or different note: relatch HALF and note_id; tone_cnt = 0; tone = 1; hold_cnt = 0; release_pending = 0.
  - The phase restarts in the next cycle.
- PLAY state, release:
  - key_released with hold_cnt >= MIN_HOLD: go to IDLE next cycle.
  - key_released with hold_cnt < MIN_HOLD: set release_pending.
  - When hold_cnt reaches MIN_HOLD with release_pending = 1: go to IDLE in that cycle's transition.
- Simultaneous key_valid (known code) and key_released in the same cycle: key_valid wins; the release is discarded.
- No auto-stop: without a release the note plays indefinitely.
- Reset mid-play: outputs are 0 on the cycle after rst is sampled high; no pending state survives.

Optional Feature:
- Macro: TONE_PLAYER_DECAY_EN.
- Defined:
  - An 8-bit envelope env is loaded with 255 on every accepted note.
  - env decrements by 1 every DECAY_STEP cycles while in PLAY and stops at DECAY_FLOOR.
  - An 8-bit free-running pwm_cnt runs; during tone-high half-periods, AUD_PWM = (pwm_cnt < env).
  - During tone-low half-periods, AUD_PWM = 0.
  - State machine, timing and all other outputs are unchanged.
- Undefined: pure square wave as described above; no env or pwm_cnt logic is synthesized.

Test Plan:
- Reset: hold rst high 3 cycles, then release -> AUD_PWM = 0, AUD_SD = 0, busy = 0, note_id = 0 until the first event.
- Play DO (TEST_DIV = 1000, MIN_HOLD = 1000): key_valid with key_code = 1A -> next cycle AUD_SD = 1, busy = 1, note_id = 1, AUD_PWM = 1; AUD_PWM toggles every 191 cycles (period 382).
- Early release: key_released 200 cycles after the note -> stays in PLAY until hold_cnt = 1000, then next cycle AUD_SD = 0, note_id = 0. Separately, a release at cycle 1500 -> IDLE on the next cycle.
- Note change: during DO, key_valid with 3A -> next cycle note_id = 7, AUD_PWM = 1, half-period 101; hold restarts, so a release 500 cycles later is deferred to 1000.
- Edge events:
  - key_valid with 15 in IDLE and in PLAY -> no change.
  - key_valid 21 plus key_released in the same cycle -> note_id = 3, still playing.
  - key_released in IDLE -> ignored.
- Reset mid-play: rst asserted during the SO note -> next cycle all outputs 0; a new key_valid 32 then restarts cleanly. With TONE_PLAYER_DECAY_EN, DECAY_STEP = 4: env reaches 32 after 223*4 cycles and stays there.

Source files
------------

// File: rtl/tone_player.sv
// Key-event driven solfege tone player (DO..SI) with minimum note hold time.
// Optional envelope decay PWM when TONE_PLAYER_DECAY_EN is defined.
module tone_player #(
  parameter int unsigned MIN_HOLD = 25000000,
  parameter int unsigned TEST_DIV = 1
`ifdef TONE_PLAYER_DECAY_EN
  ,
  parameter int unsigned DECAY_STEP  = 65536,
  parameter int unsigned DECAY_FLOOR = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  input  logic       key_released,
  output logic       AUD_PWM,
  output logic       AUD_SD,
  output logic       busy,
  output logic [2:0] note_id
);

  localparam int unsigned HALF_W = 18;
  localparam int unsigned HOLD_W = (MIN_HOLD < 2) ? 1 : $clog2(MIN_HOLD + 1);

  localparam logic [HALF_W-1:0] HALF_DO = HALF_W'(191113 / TEST_DIV);
  localparam logic [HALF_W-1:0] HALF_RE = HALF_W'(170262 / TEST_DIV);
  localparam logic [HALF_W-1:0] HALF_MI = HALF_W'(151686 / TEST_DIV);
  localparam logic [HALF_W-1:0] HALF_FA = HALF_W'(143172 / TEST_DIV);
  localparam logic [HALF_W-1:0] HALF_SO = HALF_W'(127551 / TEST_DIV);
  localparam logic [HALF_W-1:0] HALF_LA = HALF_W'(113636 / TEST_DIV);
  localparam logic [HALF_W-1:0] HALF_SI = HALF_W'(101239 / TEST_DIV);

  typedef enum logic {IDLE, PLAY} state_t;

  state_t              state, state_nx;
  logic [HALF_W-1:0]   half, half_nx;
  logic [HALF_W-1:0]   tone_cnt, tone_cnt_nx;
  logic                tone, tone_nx;
  logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nx;
  logic                release_pending, release_pending_nx;
  logic [2:0]          note, note_nx;
  logic                pwm_nx, sd_nx;
  logic [2:0]          note_id_nx;

  logic                known;
  logic [2:0]          key_id;
  logic [HALF_W-1:0]   key_half;
  logic                accept;
  logic                hold_done;

`ifdef TONE_PLAYER_DECAY_EN
  localparam int unsigned STEP_W = (DECAY_STEP < 2) ? 1 : $clog2(DECAY_STEP);
  logic [7:0]        env, env_nx;
  logic [STEP_W-1:0] step_cnt, step_cnt_nx;
  logic [7:0]        pwm_cnt, pwm_cnt_nx;
`endif

  // Scancode to note number and half-period
  always_comb begin
    known    = 1'b1;
    key_id   = 3'd0;
    key_half = '0;
    case (key_code)
      8'h1A: begin key_id = 3'd1; key_half = HALF_DO; end
      8'h22: begin key_id = 3'd2; key_half = HALF_RE; end
      8'h21: begin key_id = 3'd3; key_half = HALF_MI; end
      8'h2A: begin key_id = 3'd4; key_half = HALF_FA; end
      8'h32: begin key_id = 3'd5; key_half = HALF_SO; end
      8'h31: begin key_id = 3'd6; key_half = HALF_LA; end
      8'h3A: begin key_id = 3'd7; key_half = HALF_SI; end
      default: known = 1'b0;
    endcase
  end

  assign accept    = key_valid && known;
  assign hold_done = (hold_cnt >= HOLD_W'(MIN_HOLD));

  // Next-state, datapath and output logic; an accepted key overrides any release
  always_comb begin
    state_nx           = state;
    half_nx            = half;
    tone_cnt_nx        = tone_cnt;
    tone_nx            = tone;
    hold_cnt_nx        = hold_cnt;
    release_pending_nx = release_pending;
    note_nx            = note;
`ifdef TONE_PLAYER_DECAY_EN
    env_nx      = env;
    step_cnt_nx = step_cnt;
    pwm_cnt_nx  = pwm_cnt + 8'd1;
`endif

    if (accept) begin
      state_nx           = PLAY;
      half_nx            = key_half;
      note_nx            = key_id;
      tone_cnt_nx        = '0;
      tone_nx            = 1'b1;
      hold_cnt_nx        = '0;
      release_pending_nx = 1'b0;
`ifdef TONE_PLAYER_DECAY_EN
      env_nx      = 8'd255;
      step_cnt_nx = '0;
`endif
    end else if (state == PLAY) begin
      if (tone_cnt == half - HALF_W'(1)) begin
        tone_cnt_nx = '0;
        tone_nx     = ~tone;
      end else begin
        tone_cnt_nx = tone_cnt + HALF_W'(1);
      end
      if (!hold_done) hold_cnt_nx = hold_cnt + HOLD_W'(1);
`ifdef TONE_PLAYER_DECAY_EN
      if (step_cnt == STEP_W'(DECAY_STEP - 1)) begin
        step_cnt_nx = '0;
        if (env > 8'(DECAY_FLOOR)) env_nx = env - 8'd1;
      end else begin
        step_cnt_nx = step_cnt + STEP_W'(1);
      end
`endif
      if ((key_released || release_pending) && hold_done) begin
        state_nx           = IDLE;
        release_pending_nx = 1'b0;
        tone_cnt_nx        = '0;
        tone_nx            = 1'b0;
        note_nx            = 3'd0;
      end else if (key_released) begin
        release_pending_nx = 1'b1;
      end
    end

    sd_nx      = (state_nx == PLAY);
    note_id_nx = sd_nx ? note_nx : 3'd0;
`ifdef TONE_PLAYER_DECAY_EN
    pwm_nx = sd_nx && tone_nx && (pwm_cnt_nx < env_nx);
`else
    pwm_nx = sd_nx && tone_nx;
`endif
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      half            <= '0;
      tone_cnt        <= '0;
      tone            <= 1'b0;
      hold_cnt        <= '0;
      release_pending <= 1'b0;
      note            <= 3'd0;
      AUD_PWM         <= 1'b0;
      AUD_SD          <= 1'b0;
      busy            <= 1'b0;
      note_id         <= 3'd0;
`ifdef TONE_PLAYER_DECAY_EN
      env      <= 8'd0;
      step_cnt <= '0;
      pwm_cnt  <= 8'd0;
`endif
    end else begin
      state           <= state_nx;
      half            <= half_nx;
      tone_cnt        <= tone_cnt_nx;
      tone            <= tone_nx;
      hold_cnt        <= hold_cnt_nx;
      release_pending <= release_pending_nx;
      note            <= note_nx;
      AUD_PWM         <= pwm_nx;
      AUD_SD          <= sd_nx;
      busy            <= sd_nx;
      note_id         <= note_id_nx;
`ifdef TONE_PLAYER_DECAY_EN
      env      <= env_nx;
      step_cnt <= step_cnt_nx;
      pwm_cnt  <= pwm_cnt_nx;
`endif
    end
  end

endmodule

// File: tb/tb_tone_player.sv
// Self-checking bench for tone_player: expected output vectors are queued as
// stimulus is applied and popped for comparison against the sampled outputs.
module tb_tone_player;

  localparam int unsigned MIN_HOLD = 1000;
  localparam int unsigned TEST_DIV = 1000;

  logic       clk = 1'b0;
  logic       rst;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_released;
  logic       AUD_PWM, AUD_SD, busy;
  logic [2:0] note_id;
  logic [5:0] obs;

  always #5 clk = ~clk;

  tone_player #(
    .MIN_HOLD(MIN_HOLD),
    .TEST_DIV(TEST_DIV)
`ifdef TONE_PLAYER_DECAY_EN
    ,
    .DECAY_STEP(4),
    .DECAY_FLOOR(32)
`endif
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_released(key_released),
    .AUD_PWM(AUD_PWM),
    .AUD_SD(AUD_SD),
    .busy(busy),
    .note_id(note_id)
  );

  assign obs = {AUD_SD, busy, note_id, AUD_PWM};

  typedef struct {
    string      name;
    logic [5:0] v;
    logic [5:0] m;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   k       = 0;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    k += n;
  endtask

  task automatic key(input logic [7:0] c);
    key_valid = 1'b1;
    key_code  = c;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic rel();
    key_released = 1'b1;
    tick();
    key_released = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic tn(input int kk, input int h);
    return ((kk / h) % 2) == 0;
  endfunction

  // Expected {AUD_SD, busy, note_id, AUD_PWM}; envelope PWM leaves the high phase unchecked
  task automatic push(input string name, input logic p, input logic [2:0] n, input logic t);
    exp_t x;
    x.name = name;
    x.v    = {p, p, (p ? n : 3'd0), p & t};
`ifdef TONE_PLAYER_DECAY_EN
    x.m = (p && t) ? 6'b111110 : 6'b111111;
`else
    x.m = 6'b111111;
`endif
    exp_q.push_back(x);
  endtask

  task automatic test_reset();
    key_valid = 1'b0; key_released = 1'b0; key_code = 8'h00;
    rst = 1'b1;
    tick(3);
    push("reset_asserted", 0, 0, 0);
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    rst = 1'b0;
    tick(5);
    push("reset_released_idle", 0, 0, 0);
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
  endtask

  task automatic test_play_do();
    int cks[4] = '{190, 191, 381, 382};
    do_reset();
    key(8'h1A); k = 0;
    push("do_start", 1, 1, 1);
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    foreach (cks[i]) begin
      tick(cks[i] - k);
      push($sformatf("do_tone_k%0d", k), 1, 1, tn(k, 191));
      e = exp_q.pop_front(); n_tests++;
      if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    end
  endtask

  task automatic test_release();
    do_reset();
    key(8'h1A); k = 0;
    tick(200);
    rel();
    tick(1000 - k);
    push("early_rel_still_play", 1, 1, tn(k, 191));
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    tick();
    push("early_rel_idle", 0, 0, 0);
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    key(8'h1A); k = 0;
    tick(1500);
    push("late_rel_before", 1, 1, tn(k, 191));
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    rel();
    push("late_rel_idle", 0, 0, 0);
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
  endtask

  task automatic test_note_change();
    do_reset();
    key(8'h1A); k = 0;
    tick(300);
    key(8'h3A); k = 0;
    push("si_start", 1, 7, 1);
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    tick(100);
    push("si_high_end", 1, 7, tn(k, 101));
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    tick();
    push("si_low_start", 1, 7, tn(k, 101));
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    tick(500 - k);
    rel();
    tick(1000 - k);
    push("si_deferred_play", 1, 7, tn(k, 101));
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    tick();
    push("si_deferred_idle", 0, 0, 0);
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
  endtask

  task automatic test_edge_events();
    do_reset();
    key(8'h15);
    push("unknown_in_idle", 0, 0, 0);
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    rel();
    push("release_in_idle", 0, 0, 0);
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    key(8'h32); k = 0;
    tick(49);
    key(8'h15);
    push("unknown_in_play", 1, 5, tn(k, 127));
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    tick(127 - k);
    push("unknown_no_restart", 1, 5, tn(k, 127));
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    tick(1200 - k);
    key_valid = 1'b1; key_code = 8'h21; key_released = 1'b1;
    tick();
    key_valid = 1'b0; key_released = 1'b0; k = 0;
    push("valid_beats_release", 1, 3, 1);
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    tick(1001);
    push("release_discarded", 1, 3, tn(k, 151));
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    rel();
    push("mi_release_idle", 0, 0, 0);
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
  endtask

  task automatic test_reset_mid_play();
    do_reset();
    key(8'h32); k = 0;
    tick(50);
    rel();
    do_reset();
    push("mid_play_reset", 0, 0, 0);
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    key(8'h32); k = 0;
    push("so_restart", 1, 5, 1);
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    tick(127);
    push("so_restart_low", 1, 5, tn(k, 127));
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
    tick(1001 - k);
    push("so_no_stale_pending", 1, 5, tn(k, 127));
    e = exp_q.pop_front(); n_tests++;
    if ((obs & e.m) !== (e.v & e.m)) begin n_fail++; $display("FAIL %s: observed %b expected %b", e.name, obs, e.v); end
  endtask

`ifdef TONE_PLAYER_DECAY_EN
  task automatic test_decay();
    int pts[4] = '{0, 891, 892, 1300};
    logic [7:0] want;
    do_reset();
    key(8'h1A); k = 0;
    foreach (pts[i]) begin
      tick(pts[i] - k);
      want = ((255 - k / 4) < 32) ? 8'd32 : 8'(255 - k / 4);
      n_tests++;
      if (dut.env !== want) begin
        n_fail++;
        $display("FAIL decay_env_k%0d: observed %0d expected %0d", k, dut.env, want);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_play_do();
    test_release();
    test_note_change();
    test_edge_events();
    test_reset_mid_play();
`ifdef TONE_PLAYER_DECAY_EN
    test_decay();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
